// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared flit encodings, field positions and the framing-state
//            definition for the NoC router input stage.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Flit-type codes carried in the top three bits of every flit.
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;

  // flit_id occupies [DATA_WIDTH-FLIT_ID_MSB -: FLIT_ID_W].
  localparam int FLIT_ID_W    = 3;
  localparam int FLIT_ID_MSB  = 1;

  // Destination field of a header flit: y in [3:2], x in [1:0].
  localparam int DST_ADDR_LSB = 0;
  localparam int DST_ADDR_W   = 4;

  // Packet framing tracker state.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

  // Result of advancing the framing tracker by one accepted flit.
  typedef struct packed {
    frame_state_t next;
    logic         err;
  } frame_step_t;

  // Next framing state and error flag for one accepted flit. Unknown codes
  // and out-of-order types are flagged; the state only moves on legal
  // transitions, except that a HEADER always (re)opens a packet.
  function automatic frame_step_t frame_step(input frame_state_t  state,
                                             input logic [FLIT_ID_W-1:0] id);
    frame_step_t res;
    res.next = state;
    res.err  = 1'b0;
    case (id)
      HEADER: begin
        res.err  = (state == IN_PKT);
        res.next = IN_PKT;
      end
      BODY: begin
        res.err  = (state == IDLE);
      end
      TAIL: begin
        res.err  = (state == IDLE);
        res.next = IDLE;
      end
      default: begin
        res.err  = 1'b1;
      end
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : noc_fifo_mem
// Purpose  : Circular flit buffer with read/write pointers and occupancy
//            count. Head entry is presented combinationally (FWFT).
// Revision : 1.0 - initial release
// ============================================================================
module noc_fifo_mem
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_req,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_req,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_wr_acc,
  output logic                  o_rd_acc
);

  localparam logic [PTR_W:0]   c_FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE    = PTR_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Status flags come straight from the registered count; a full buffer
  // refuses writes even when a read frees a slot in the same cycle.
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == c_FULL_COUNT);
  assign w_wr_acc = i_wr_req & ~o_full & ~rst;
  assign w_rd_acc = i_rd_req & ~o_empty & ~rst;
  assign o_wr_acc = w_wr_acc;
  assign o_rd_acc = w_rd_acc;

  // Head flit; contents are stale while empty and must be qualified.
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH = 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_input_fifo.sv
`default_nettype none
// ============================================================================
// Module   : noc_input_fifo
// Purpose  : Router input-port buffer. Stores incoming flits under credit
//            flow control, presents the head flit and its decoded fields to
//            LBDR/crossbar, returns credits and checks packet framing.
// Revision : 1.0 - initial release
// ============================================================================
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] flit_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out,
  output logic                  overflow_err,
  output logic                  framing_err
);

  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [FLIT_ID_W-1:0] w_in_id;
  frame_step_t          w_step;
  frame_state_t         r_state;

  noc_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_req  (valid_in),
    .i_wr_data (flit_in),
    .i_rd_req  (read_en),
    .o_rd_data (flit_out),
    .o_empty   (empty),
    .o_full    (full),
    .o_wr_acc  (w_wr_acc),
    .o_rd_acc  (w_rd_acc)
  );

  // Head-flit field decode for LBDR; dst_addr only meaningful on a HEADER.
  assign flit_id  = flit_out[DATA_WIDTH-FLIT_ID_MSB -: FLIT_ID_W];
  assign dst_addr = flit_out[DST_ADDR_LSB +: DST_ADDR_W];

  // Framing decision for the flit currently arriving.
  assign w_in_id = flit_in[DATA_WIDTH-FLIT_ID_MSB -: FLIT_ID_W];
  assign w_step  = frame_step(r_state, w_in_id);

  // One credit back upstream for every flit consumed in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_out <= 1'b0;
    end else begin
      credit_out <= w_rd_acc;
    end
  end

  // Sticky flag: upstream sent a flit it had no credit for.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (valid_in && full) begin
      overflow_err <= 1'b1;
    end
  end

  // Framing tracker advanced on accepted writes; offending flits are kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      framing_err <= 1'b0;
    end else if (w_wr_acc) begin
      r_state <= w_step.next;
      if (w_step.err) begin
        framing_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_input_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_input_fifo
// Purpose  : Self-checking bench for noc_input_fifo: directed vector table,
//            hand-written multi-cycle sequences and randomized traffic
//            checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  localparam logic [2:0] ID_H = 3'b001;
  localparam logic [2:0] ID_B = 3'b010;
  localparam logic [2:0] ID_T = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] flit_in;
  logic          read_en;
  logic [DW-1:0] flit_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic          empty;
  logic          full;
  logic          credit_out;
  logic          overflow_err;
  logic          framing_err;

  always #5 clk = ~clk;

  noc_input_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .flit_in      (flit_in),
    .read_en      (read_en),
    .flit_out     (flit_out),
    .flit_id      (flit_id),
    .dst_addr     (dst_addr),
    .empty        (empty),
    .full         (full),
    .credit_out   (credit_out),
    .overflow_err (overflow_err),
    .framing_err  (framing_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: buffer contents as a queue plus flag values.
  logic [DW-1:0] mq[$];
  logic          m_credit = 1'b0;
  logic          m_ovf    = 1'b0;
  logic          m_ferr   = 1'b0;
  logic          m_in_pkt = 1'b0;

  typedef struct {
    logic          rst;
    logic          valid;
    logic [DW-1:0] flit;
    logic          read;
    logic          e_empty;
    logic          e_full;
    logic          e_credit;
    logic          e_ovf;
    logic          e_ferr;
    logic [DW-1:0] e_head;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] mk(input logic [2:0] id, input int pay,
                                       input logic [3:0] dst);
    logic [24:0] p;
    p = pay[24:0];
    return {id, p, dst};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge, from the rules of the buffer.
  task automatic model_edge(input logic r, input logic v,
                            input logic [DW-1:0] f, input logic rd);
    bit          was_full;
    bit          was_empty;
    logic [2:0]  id;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (r) begin
      mq.delete();
      m_credit = 1'b0;
      m_ovf    = 1'b0;
      m_ferr   = 1'b0;
      m_in_pkt = 1'b0;
    end else begin
      m_credit = rd && !was_empty;
      if (v && was_full) m_ovf = 1'b1;
      if (rd && !was_empty) void'(mq.pop_front());
      if (v && !was_full) begin
        mq.push_back(f);
        id = f[31:29];
        if (id == ID_H) begin
          if (m_in_pkt) m_ferr = 1'b1;
          m_in_pkt = 1'b1;
        end else if (id == ID_B) begin
          if (!m_in_pkt) m_ferr = 1'b1;
        end else if (id == ID_T) begin
          if (!m_in_pkt) m_ferr = 1'b1;
          m_in_pkt = 1'b0;
        end else begin
          m_ferr = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [DW-1:0] head;
    chk("m_empty",  32'(empty),        32'(mq.size() == 0));
    chk("m_full",   32'(full),         32'(mq.size() == DEPTH));
    chk("m_credit", 32'(credit_out),   32'(m_credit));
    chk("m_ovf",    32'(overflow_err), 32'(m_ovf));
    chk("m_ferr",   32'(framing_err),  32'(m_ferr));
    if (mq.size() != 0) begin
      head = mq[0];
      chk("m_flit_out", flit_out,        head);
      chk("m_flit_id",  32'(flit_id),    32'(head[31:29]));
      chk("m_dst_addr", 32'(dst_addr),   32'(head[3:0]));
    end
  endtask

  // Drive one cycle of inputs, clock, update model, sample after the edge.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] f,
                      input logic rd);
    rst      = r;
    valid_in = v;
    flit_in  = f;
    read_en  = rd;
    @(posedge clk);
    model_edge(r, v, f, rd);
    cyc++;
    #1;
    compare_model();
  endtask

  task automatic add(input logic r, input logic v, input logic [DW-1:0] f,
                     input logic rd, input logic ee, input logic ef,
                     input logic ec, input logic eo, input logic efr,
                     input logic [DW-1:0] eh);
    vec_t t;
    t.rst = r; t.valid = v; t.flit = f; t.read = rd;
    t.e_empty = ee; t.e_full = ef; t.e_credit = ec;
    t.e_ovf = eo; t.e_ferr = efr; t.e_head = eh;
    tbl.push_back(t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int            credits;
    logic [DW-1:0] eh;
    logic [2:0]    eid;
    logic [2:0]    rid;
    logic [2:0]    odd_ids [5];

    rst = 1'b1; valid_in = 1'b0; flit_in = '0; read_en = 1'b0;

    //   rst v  flit              rd  empty full cred ovf ferr head
    add(1, 0, '0,                  0,  1, 0, 0, 0, 0, '0);
    add(0, 1, mk(ID_H, 1, 4'hA),   0,  0, 0, 0, 0, 0, mk(ID_H, 1, 4'hA));
    add(0, 0, '0,                  1,  1, 0, 1, 0, 0, '0);
    add(0, 0, '0,                  0,  1, 0, 0, 0, 0, '0);
    add(0, 1, mk(ID_B, 2, 4'h1),   0,  0, 0, 0, 0, 0, mk(ID_B, 2, 4'h1));
    add(0, 1, mk(ID_B, 3, 4'h2),   0,  0, 0, 0, 0, 0, mk(ID_B, 2, 4'h1));
    add(0, 1, mk(ID_B, 4, 4'h3),   0,  0, 0, 0, 0, 0, mk(ID_B, 2, 4'h1));
    add(0, 1, mk(ID_T, 5, 4'h4),   0,  0, 1, 0, 0, 0, mk(ID_B, 2, 4'h1));
    add(0, 1, mk(ID_H, 6, 4'h5),   0,  0, 1, 0, 1, 0, mk(ID_B, 2, 4'h1));
    add(0, 1, mk(ID_H, 7, 4'h6),   1,  0, 0, 1, 1, 0, mk(ID_B, 3, 4'h2));
    add(0, 0, '0,                  1,  0, 0, 1, 1, 0, mk(ID_B, 4, 4'h3));
    add(0, 0, '0,                  1,  0, 0, 1, 1, 0, mk(ID_T, 5, 4'h4));
    add(0, 0, '0,                  1,  1, 0, 1, 1, 0, '0);
    add(0, 0, '0,                  0,  1, 0, 0, 1, 0, '0);
    add(1, 0, '0,                  0,  1, 0, 0, 0, 0, '0);
    add(0, 1, mk(ID_B, 8, 4'h0),   0,  0, 0, 0, 0, 1, mk(ID_B, 8, 4'h0));
    add(0, 1, mk(ID_H, 9, 4'h7),   1,  0, 0, 1, 0, 1, mk(ID_H, 9, 4'h7));
    add(0, 1, mk(ID_H, 10, 4'h8),  1,  0, 0, 1, 0, 1, mk(ID_H, 10, 4'h8));
    add(0, 1, mk(ID_T, 11, 4'h0),  1,  0, 0, 1, 0, 1, mk(ID_T, 11, 4'h0));
    add(0, 1, mk(ID_H, 12, 4'h5),  0,  0, 0, 0, 0, 1, mk(ID_T, 11, 4'h0));
    add(1, 1, mk(ID_B, 13, 4'h0),  1,  1, 0, 0, 0, 0, '0);
    add(0, 1, mk(ID_H, 14, 4'h3),  0,  0, 0, 0, 0, 0, mk(ID_H, 14, 4'h3));
    add(1, 0, '0,                  0,  1, 0, 0, 0, 0, '0);
    add(0, 0, '0,                  1,  1, 0, 0, 0, 0, '0);
    add(0, 0, '0,                  1,  1, 0, 0, 0, 0, '0);
    add(0, 0, '0,                  1,  1, 0, 0, 0, 0, '0);
    add(0, 1, mk(ID_H, 15, 4'hF),  0,  0, 0, 0, 0, 0, mk(ID_H, 15, 4'hF));
    add(0, 0, '0,                  1,  1, 0, 1, 0, 0, '0);
    add(0, 1, mk(3'b011, 16, 4'h9),0,  0, 0, 0, 0, 1, mk(3'b011, 16, 4'h9));
    add(0, 0, '0,                  1,  1, 0, 1, 0, 1, '0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].flit, tbl[i].read);
      chk("t_empty",  32'(empty),        32'(tbl[i].e_empty));
      chk("t_full",   32'(full),         32'(tbl[i].e_full));
      chk("t_credit", 32'(credit_out),   32'(tbl[i].e_credit));
      chk("t_ovf",    32'(overflow_err), 32'(tbl[i].e_ovf));
      chk("t_ferr",   32'(framing_err),  32'(tbl[i].e_ferr));
      if (!tbl[i].e_empty) begin
        eh  = tbl[i].e_head;
        eid = eh[31:29];
        chk("t_flit_out", flit_out,     eh);
        chk("t_flit_id",  32'(flit_id), 32'(eid));
        if (eid == ID_H) chk("t_dst_addr", 32'(dst_addr), 32'(eh[3:0]));
      end
    end

    // Steady occupancy of two with a read and write every cycle.
    step(1, 0, '0, 0);
    step(0, 1, mk(ID_H, 100, 4'h2), 0);
    step(0, 1, mk(ID_B, 101, 4'h0), 0);
    credits = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, mk(ID_B, 102 + i, 4'h0), 1);
      credits += int'(credit_out);
      chk("w_not_empty", 32'(empty), 32'(0));
      chk("w_not_full",  32'(full),  32'(0));
      chk("w_head",      flit_out,   mk(ID_B, 101 + i, 4'h0));
    end
    chk("w_credits", 32'(credits), 32'(10));
    step(0, 1, mk(ID_T, 200, 4'h0), 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
    chk("w_drained", 32'(empty), 32'(1));
    chk("w_no_ferr", 32'(framing_err), 32'(0));

    // Randomized traffic against the reference model.
    odd_ids[0] = 3'b000; odd_ids[1] = 3'b011; odd_ids[2] = 3'b101;
    odd_ids[3] = 3'b110; odd_ids[4] = 3'b111;
    step(1, 0, '0, 0);
    for (int i = 0; i < 3000; i++) begin
      int pick;
      int wr_pct;
      logic r;
      logic v;
      logic rd;
      pick = int'($urandom_range(0, 19));
      if      (pick < 5)  rid = ID_H;
      else if (pick < 13) rid = ID_B;
      else if (pick < 18) rid = ID_T;
      else                rid = odd_ids[$urandom_range(0, 4)];
      wr_pct = ((i / 500) % 2 == 0) ? 75 : 35;
      r  = ($urandom_range(0, 149) == 0);
      v  = (int'($urandom_range(0, 99)) < wr_pct);
      rd = ($urandom_range(0, 99) < 50);
      step(r, v, mk(rid, int'($urandom_range(0, 32'h1FFFFFF)),
                    4'($urandom_range(0, 15))), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_input_fifo.md
Name: noc_input_fifo

Overview:
- Per-port input buffer of the mesh NoC router, placed directly upstream of the LBDR routing stage.
- Accepts flits from the neighbouring router's output link under credit-based flow control and stores them in a small circular buffer.
- Presents the head flit first-word-fall-through: decoded flit_id, dst_addr and empty go to LBDR; the full flit goes to the crossbar.
- Returns one credit per flit consumed and checks packet framing (HEADER ... TAIL).

Parameters:
- DATA_WIDTH, 32, flit width in bits. Must be at least 7.
- DEPTH, 4, buffer entries. Must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width, derived.

Ports:
- clk  in  1  router clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  upstream flit valid; one flit per cycle
- flit_in  in  DATA_WIDTH  incoming flit
- read_en  in  1  downstream (allocator/crossbar) pops head flit
- flit_out  out  DATA_WIDTH  head flit, combinational from storage
- flit_id  out  3  flit_out[DATA_WIDTH-1 -: 3], to LBDR
- dst_addr  out  4  flit_out[3:0] of a header flit (y in [3:2], x in [1:0]), to LBDR
- empty  out  1  no stored flit, to LBDR
- full  out  1  all DEPTH entries occupied
- credit_out  out  1  one-cycle pulse per flit popped, to upstream
- overflow_err  out  1  sticky: write attempted while full
- framing_err  out  1  sticky: packet-order violation

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
  - credit_out=0, overflow_err=0, framing_err=0, framing state=IDLE.
  - Storage contents are not reset. flit_out is don't-care while empty.
- rst has priority over every other input in the same cycle. Reset mid-packet discards all stored flits and returns framing to IDLE.
- Write: valid_in=1 and full=0 -> mem[wr_ptr]<=flit_in; wr_ptr increments and wraps modulo DEPTH.
- Write when full: valid_in=1 and full=0 is false -> flit dropped, overflow_err<=1 (sticky until rst). This holds even if read_en=1 in the same cycle; there is no pass-through when full.
- Read: read_en=1 and empty=0 -> rd_ptr increments and wraps; credit_out<=1 in the next cycle.
- read_en while empty is ignored: no pointer move, no credit.
- Simultaneous accepted read and write: count unchanged, both pointers advance, credit issued.
- count width is PTR_W+1. empty=(count==0) and full=(count==DEPTH), both registered-derived from count.
- Latency:
  - A flit written at edge N is visible on flit_out/flit_id/dst_addr with empty=0 after edge N.
  - LBDR therefore samples it at edge N+1.
- credit_out is registered: it equals "accepted read in the previous cycle". Upstream starts with DEPTH credits.
- Framing FSM, evaluated on accepted writes only:
  - IDLE: HEADER -> IN_PKT. BODY or TAIL -> framing_err<=1, stay IDLE.
  - IN_PKT: BODY -> IN_PKT. TAIL -> IDLE. HEADER -> framing_err<=1, stay IN_PKT (new packet).
  - A flit_id matching no defined code sets framing_err in either state; the state is unchanged.
  - Flits that cause a framing error are still stored; the error is flagged only.
- flit_id/dst_addr are pure decodes of flit_out. dst_addr is meaningful only when flit_id==HEADER.

Decomposition:
- Shared package noc_pkg holds:
  - flit-type constants HEADER=3'b001, BODY=3'b010, TAIL=3'b100
  - field positions (FLIT_ID_MSB offset, DST_ADDR_LSB=0, DST_ADDR_W=4)
  - framing state enum {IDLE, IN_PKT}
- One natural sub-module, noc_fifo_mem: storage array, pointers and count, producing full/empty. The top level adds the field decode, credit register and framing FSM.

Test Plan:
- Reset, then write HEADER with dst_addr=4'b1010 -> next cycle empty=0, flit_id=3'b001, dst_addr=4'b1010; pop -> credit_out=1 exactly one cycle later, empty=1.
- Write 4 flits with no reads (DEPTH=4) -> full=1 after the 4th; 5th write -> dropped, overflow_err=1; pop all -> order preserved, 4 credit pulses.
- Full buffer with valid_in=1 and read_en=1 in the same cycle -> write dropped, overflow_err=1, count=3.
- Count=2 with simultaneous read and write each cycle for 10 cycles -> count stays 2, pointers wrap, flit order intact, 10 credits.
- Sequence BODY, then HEADER, HEADER, TAIL -> framing_err=1 after the first BODY and remains set; stays 1 until rst; rst mid-packet -> empty=1, framing_err=0.
- read_en=1 while empty for 3 cycles -> no credit_out, pointers unchanged, empty=1.
